// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory req/ack port between the MEM stage and memory
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: load/store sequencing, data formatting, writeback select
module mem_access_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  ex_rf_we,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_uns,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_rd2,
    input  logic [4:0]  ex_wR,
    input  logic [31:0] ex_pc,
    input  logic        ex_flag,
    output logic        stall,
    mem_access_unit_if.master bus,
    output logic [1:0]  wb_rf_we,
    output logic [31:0] wb_wD,
    output logic [4:0]  wb_wR,
    output logic [31:0] wb_pc,
    output logic        wb_flag
);
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACCESS = 2'b01;
    localparam logic [1:0] S_DONE   = 2'b10;
    localparam logic [1:0] S_ERR    = 2'b11;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   load_q, load_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;

    logic [1:0]  off;
    logic        mem_op, illegal;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt, rshift, load_fmt, pass_wd;

    always_comb begin
        off     = ex_alu[1:0];
        mem_op  = ex_valid & (ex_mem_rd | ex_mem_wr);
        illegal = (ex_mem_rd & ex_mem_wr) | (ex_mem_size == 2'b11)
                | ((ex_mem_size == 2'b01) & off[0])
                | ((ex_mem_size == 2'b10) & (off != 2'b00));
        rshift  = bus.dmem_rdata >> {off, 3'b000};
        pass_wd = (ex_rf_we == 2'b11) ? ex_pc + 32'd4 : ex_alu;
        case (ex_mem_size)
            2'b00: begin
                be_fmt    = 4'b0001 << off;
                wdata_fmt = {4{ex_rd2[7:0]}};
                load_fmt  = ex_mem_uns ? {24'd0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
            end
            2'b01: begin
                be_fmt    = off[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{ex_rd2[15:0]}};
                load_fmt  = ex_mem_uns ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = ex_rd2;
                load_fmt  = rshift;
            end
        endcase
    end

    // Bus outputs are registered and held untouched for the whole ACCESS phase.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op && !illegal) begin
                    req_d   = 1'b1;
                    we_d    = ex_mem_wr;
                    addr_d  = {ex_alu[31:2], 2'b00};
                    wdata_d = wdata_fmt;
                    be_d    = be_fmt;
                    count_d = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.dmem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    load_d  = load_fmt;
                    state_d = S_DONE;
                end else if (count_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_ERR;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        wb_rf_we = ex_rf_we;
        wb_wD    = pass_wd;
        wb_wR    = ex_wR;
        wb_pc    = ex_pc;
        wb_flag  = ex_flag;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall    = ~illegal;
                    wb_rf_we = 2'b00;
                    wb_flag  = illegal;
                end
            end
            S_ACCESS: begin
                stall    = 1'b1;
                wb_rf_we = 2'b00;
                wb_flag  = 1'b0;
            end
            S_DONE: begin
                if (ex_rf_we == 2'b10) wb_wD = load_q;
            end
            default: begin
                wb_rf_we = 2'b00;
                wb_flag  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            load_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_be    = be_q;
endmodule
